// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue controller.
// Field layout of an instruction: [opc | ra | rb | rd], rd in the low bits.
package alu_issue_pkg;

  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 4;
  localparam int OPC_W_DEF   = 4;
  localparam int INSTR_W_DEF = OPC_W_DEF + 3 * ADDR_W_DEF;

  localparam int RD_LSB  = 0;
  localparam int RB_LSB  = ADDR_W_DEF;
  localparam int RA_LSB  = 2 * ADDR_W_DEF;
  localparam int OPC_LSB = 3 * ADDR_W_DEF;

  // First opcode value with no ALU function behind it
  localparam int ILLEGAL_MIN = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    EXEC  = 3'd2,
    WRITE = 3'd3,
    ERR   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_CLR  = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_PASS = 3'd3,
    OP_XOR  = 3'd4,
    OP_OR   = 3'd5,
    OP_AND  = 3'd6,
    OP_INC  = 3'd7
  } opcode_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational instruction field splitter: opcode -> ALU select plus an
// illegal flag for opcodes outside the ALU function range.
module alu_issue_decode
  import alu_issue_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OPC_W  = OPC_W_DEF
) (
  input  logic [OPC_W+3*ADDR_W-1:0] instr,
  output opcode_t                   sel,
  output logic [ADDR_W-1:0]         ra,
  output logic [ADDR_W-1:0]         rb,
  output logic [ADDR_W-1:0]         rd,
  output logic                      illegal
);

  localparam int RD_POS  = 0;
  localparam int RB_POS  = ADDR_W;
  localparam int RA_POS  = 2 * ADDR_W;
  localparam int OPC_POS = 3 * ADDR_W;

  logic [OPC_W-1:0] opc;

  assign opc     = instr[OPC_POS +: OPC_W];
  assign ra      = instr[RA_POS +: ADDR_W];
  assign rb      = instr[RB_POS +: ADDR_W];
  assign rd      = instr[RD_POS +: ADDR_W];
  assign sel     = opcode_t'(opc[2:0]);
  assign illegal = (opc >= OPC_W'(ILLEGAL_MIN));

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction, reads operands, drives the ALU and
// writes back the result. Optional flag outputs are enabled by ALU_ISSUE_FLAGS_EN.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OPC_W  = OPC_W_DEF
) (
  input  logic                      Clock,
  input  logic                      ResetN,
  input  logic                      InstrValid,
  input  logic [OPC_W+3*ADDR_W-1:0] Instr,
  output logic                      InstrReady,
  output logic [ADDR_W-1:0]         RaAddr,
  output logic [ADDR_W-1:0]         RbAddr,
  input  logic [DATA_W-1:0]         RaData,
  input  logic [DATA_W-1:0]         RbData,
  output logic [DATA_W-1:0]         AluA,
  output logic [DATA_W-1:0]         AluB,
  output logic [2:0]                AluSel,
  input  logic [DATA_W-1:0]         AluQ,
  output logic                      WrEn,
  output logic [ADDR_W-1:0]         WrAddr,
  output logic [DATA_W-1:0]         WrData,
  output logic                      Done,
  output logic                      IllegalOp
`ifdef ALU_ISSUE_FLAGS_EN
  ,
  output logic                      ZeroFlag,
  output logic                      NegFlag
`endif
);

  state_t              state_reg;
  state_t              state_next;
  opcode_t             sel_reg;
  logic [ADDR_W-1:0]   ra_reg;
  logic [ADDR_W-1:0]   rb_reg;
  logic [ADDR_W-1:0]   rd_reg;
  logic [DATA_W-1:0]   op_a_reg;
  logic [DATA_W-1:0]   op_b_reg;
  logic [DATA_W-1:0]   result_reg;

  opcode_t             dec_sel;
  logic [ADDR_W-1:0]   dec_ra;
  logic [ADDR_W-1:0]   dec_rb;
  logic [ADDR_W-1:0]   dec_rd;
  logic                dec_illegal;
  logic                accept;

  alu_issue_decode #(
    .ADDR_W (ADDR_W),
    .OPC_W  (OPC_W)
  ) u_decode (
    .instr   (Instr),
    .sel     (dec_sel),
    .ra      (dec_ra),
    .rb      (dec_rb),
    .rd      (dec_rd),
    .illegal (dec_illegal)
  );

  assign accept = InstrValid && (state_reg == IDLE);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = dec_illegal ? ERR : READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    InstrReady = 1'b0;
    AluSel     = 3'd0;
    WrEn       = 1'b0;
    Done       = 1'b0;
    IllegalOp  = 1'b0;
    case (state_reg)
      IDLE:  InstrReady = 1'b1;
      EXEC:  AluSel     = sel_reg;
      WRITE: begin
        WrEn = 1'b1;
        Done = 1'b1;
      end
      ERR: begin
        Done      = 1'b1;
        IllegalOp = 1'b1;
      end
      default: ;
    endcase
  end

  // Operands are captured in READ, so ra/rb == rd still sees the old value.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      sel_reg    <= OP_CLR;
      ra_reg     <= '0;
      rb_reg     <= '0;
      rd_reg     <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      result_reg <= '0;
    end else begin
      if (accept) begin
        sel_reg <= dec_sel;
        ra_reg  <= dec_ra;
        rb_reg  <= dec_rb;
        rd_reg  <= dec_rd;
      end
      if (state_reg == READ) begin
        op_a_reg <= RaData;
        op_b_reg <= RbData;
      end
      if (state_reg == EXEC) begin
        result_reg <= AluQ;
      end
    end
  end

  assign RaAddr = ra_reg;
  assign RbAddr = rb_reg;
  assign AluA   = op_a_reg;
  assign AluB   = op_b_reg;
  assign WrAddr = rd_reg;
  assign WrData = result_reg;

`ifdef ALU_ISSUE_FLAGS_EN
  logic zero_reg;
  logic neg_reg;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      zero_reg <= 1'b0;
      neg_reg  <= 1'b0;
    end else if (state_reg == WRITE) begin
      zero_reg <= (result_reg == '0);
      neg_reg  <= result_reg[DATA_W-1];
    end
  end

  assign ZeroFlag = zero_reg;
  assign NegFlag  = neg_reg;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and 16x16 register file.
// Flag checks are compiled in when ALU_ISSUE_FLAGS_EN is defined.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  ra_addr, rb_addr, wr_addr;
  logic [15:0] ra_data, rb_data, alu_a, alu_b, alu_q, wr_data;
  logic [2:0]  alu_sel;
  logic        wr_en, done, illegal_op;
`ifdef ALU_ISSUE_FLAGS_EN
  logic        zero_flag, neg_flag;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] rf [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [15:0] pl_data;

  alu_issue_ctrl dut (
    .Clock      (clk),
    .ResetN     (rst_n),
    .InstrValid (instr_valid),
    .Instr      (instr),
    .InstrReady (instr_ready),
    .RaAddr     (ra_addr),
    .RbAddr     (rb_addr),
    .RaData     (ra_data),
    .RbData     (rb_data),
    .AluA       (alu_a),
    .AluB       (alu_b),
    .AluSel     (alu_sel),
    .AluQ       (alu_q),
    .WrEn       (wr_en),
    .WrAddr     (wr_addr),
    .WrData     (wr_data),
    .Done       (done),
    .IllegalOp  (illegal_op)
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    .ZeroFlag   (zero_flag),
    .NegFlag    (neg_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational read, write on rising edge; bench preload port.
  assign ra_data = rf[ra_addr];
  assign rb_data = rf[rb_addr];
  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (wr_en) rf[wr_addr] <= wr_data;
  end

  always_comb begin
    alu_q = 16'h0000;
    case (opcode_t'(alu_sel))
      OP_CLR:  alu_q = 16'h0000;
      OP_ADD:  alu_q = alu_a + alu_b;
      OP_SUB:  alu_q = alu_a - alu_b;
      OP_PASS: alu_q = alu_a;
      OP_XOR:  alu_q = alu_a ^ alu_b;
      OP_OR:   alu_q = alu_a | alu_b;
      OP_AND:  alu_q = alu_a & alu_b;
      OP_INC:  alu_q = alu_a + 16'h0001;
      default: alu_q = 16'h0000;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic issue(input logic [15:0] ins);
    @(negedge clk);
    instr = ins; instr_valid = 1'b1;
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready instr=%h got=%b exp=1", ins, instr_ready);
    end
    @(posedge clk);
    #1 instr_valid = 1'b0; instr = 16'h0000;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000; pl_en = 1'b0;
    pl_addr = 4'd0; pl_data = 16'h0000;
    repeat (2) @(negedge clk);
    checks++;
    if ({instr_ready, wr_en, done, illegal_op} !== 4'b1000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=1000", {instr_ready, wr_en, done, illegal_op});
    end
    checks++;
    if ({alu_sel, alu_a, alu_b, wr_data} !== 51'd0) begin
      failures++;
      $display("FAIL reset_data got sel=%h a=%h b=%h wd=%h exp=0", alu_sel, alu_a, alu_b, wr_data);
    end
    checks++;
    if ({ra_addr, rb_addr, wr_addr} !== 12'd0) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=000", {ra_addr, rb_addr, wr_addr});
    end
`ifdef ALU_ISSUE_FLAGS_EN
    checks++;
    if ({zero_flag, neg_flag} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=00", {zero_flag, neg_flag});
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    preload(4'd0, 16'h0000);
  endtask

  task automatic test_add();
    preload(4'd1, 16'd5);
    preload(4'd2, 16'd3);
    issue(16'h1123);
    @(negedge clk);
    checks++;
    if ({ra_addr, rb_addr} !== 8'h12 || done !== 1'b0) begin
      failures++;
      $display("FAIL add_read got ra=%h rb=%h done=%b exp ra=1 rb=2 done=0", ra_addr, rb_addr, done);
    end
    @(negedge clk);
    checks++;
    if (alu_sel !== 3'd1 || alu_a !== 16'd5 || alu_b !== 16'd3) begin
      failures++;
      $display("FAIL add_exec got sel=%h a=%h b=%h exp sel=1 a=5 b=3", alu_sel, alu_a, alu_b);
    end
    @(negedge clk);
    checks++;
    if ({wr_en, done, illegal_op, instr_ready} !== 4'b1100 || wr_addr !== 4'd3 || wr_data !== 16'h0008) begin
      failures++;
      $display("FAIL add_write got ctl=%b wa=%h wd=%h exp ctl=1100 wa=3 wd=0008",
               {wr_en, done, illegal_op, instr_ready}, wr_addr, wr_data);
    end
    $display("txn ADD instr=1123 rd=%0d data=%h", wr_addr, wr_data);
    @(negedge clk);
    checks++;
    if ({wr_en, done, instr_ready} !== 3'b001 || alu_sel !== 3'd0 || rf[3] !== 16'h0008) begin
      failures++;
      $display("FAIL add_after got ctl=%b sel=%h r3=%h exp ctl=001 sel=0 r3=0008",
               {wr_en, done, instr_ready}, alu_sel, rf[3]);
    end
  endtask

  task automatic test_sub_wrap();
    preload(4'd1, 16'd1);
    preload(4'd2, 16'd2);
    issue(16'h2124);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd4 || wr_data !== 16'hFFFF) begin
      failures++;
      $display("FAIL sub_write got we=%b wa=%h wd=%h exp we=1 wa=4 wd=ffff", wr_en, wr_addr, wr_data);
    end
    $display("txn SUB instr=2124 rd=%0d data=%h", wr_addr, wr_data);
    @(negedge clk);
    checks++;
    if (rf[4] !== 16'hFFFF) begin
      failures++;
      $display("FAIL sub_rf got=%h exp=ffff", rf[4]);
    end
`ifdef ALU_ISSUE_FLAGS_EN
    checks++;
    if ({zero_flag, neg_flag} !== 2'b01) begin
      failures++;
      $display("FAIL sub_flags got zn=%b exp=01", {zero_flag, neg_flag});
    end
`endif
  endtask

  task automatic test_clr_inc();
    preload(4'd5, 16'h1234);
    issue(16'h0005);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd5 || wr_data !== 16'h0000) begin
      failures++;
      $display("FAIL clr_write got we=%b wa=%h wd=%h exp we=1 wa=5 wd=0000", wr_en, wr_addr, wr_data);
    end
    $display("txn CLR instr=0005 rd=%0d data=%h", wr_addr, wr_data);
    @(negedge clk);
    checks++;
    if (rf[5] !== 16'h0000) begin
      failures++;
      $display("FAIL clr_rf got=%h exp=0000", rf[5]);
    end
`ifdef ALU_ISSUE_FLAGS_EN
    checks++;
    if ({zero_flag, neg_flag} !== 2'b10) begin
      failures++;
      $display("FAIL clr_flags got zn=%b exp=10", {zero_flag, neg_flag});
    end
`endif
    issue(16'h7505);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd5 || wr_data !== 16'h0001) begin
      failures++;
      $display("FAIL inc_write got we=%b wa=%h wd=%h exp we=1 wa=5 wd=0001", wr_en, wr_addr, wr_data);
    end
    $display("txn INC instr=7505 rd=%0d data=%h", wr_addr, wr_data);
    @(negedge clk);
    checks++;
    if (rf[5] !== 16'h0001) begin
      failures++;
      $display("FAIL inc_rf got=%h exp=0001", rf[5]);
    end
`ifdef ALU_ISSUE_FLAGS_EN
    checks++;
    if ({zero_flag, neg_flag} !== 2'b00) begin
      failures++;
      $display("FAIL inc_flags got zn=%b exp=00", {zero_flag, neg_flag});
    end
`endif
  endtask

  task automatic test_illegal();
    issue(16'h9123);
    @(negedge clk);
    checks++;
    if ({done, illegal_op, wr_en, instr_ready} !== 4'b1100) begin
      failures++;
      $display("FAIL illegal_err got ctl=%b exp=1100", {done, illegal_op, wr_en, instr_ready});
    end
    $display("txn ILLEGAL instr=9123 done=%b illegal=%b", done, illegal_op);
    @(negedge clk);
    checks++;
    if ({done, illegal_op, instr_ready} !== 3'b001 || rf[3] !== 16'h0008) begin
      failures++;
      $display("FAIL illegal_after got ctl=%b r3=%h exp ctl=001 r3=0008",
               {done, illegal_op, instr_ready}, rf[3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seq [2];
    int acc_cyc [2];
    int n_acc = 0;
    int wr_cnt = 0;
    int ill_cnt = 0;
    seq[0] = 16'h5127;
    seq[1] = 16'h6128;
    acc_cyc[0] = 0;
    acc_cyc[1] = 0;
    preload(4'd8, 16'hAAAA);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (wr_en) wr_cnt++;
      if (illegal_op) ill_cnt++;
      if (instr_ready && n_acc < 2) begin
        acc_cyc[n_acc] = c;
        instr = seq[n_acc];
        instr_valid = 1'b1;
        n_acc++;
      end else if (n_acc < 2) begin
        instr = 16'h9FFF;
        instr_valid = 1'b1;
      end else if (instr_ready) begin
        instr_valid = 1'b0;
        instr = 16'h0000;
      end else begin
        instr = 16'h9FFF;
        instr_valid = 1'b1;
      end
    end
    instr_valid = 1'b0;
    checks++;
    if (n_acc !== 2 || (acc_cyc[1] - acc_cyc[0]) !== 4) begin
      failures++;
      $display("FAIL b2b_spacing got accepts=%0d gap=%0d exp accepts=2 gap=4", n_acc, acc_cyc[1] - acc_cyc[0]);
    end
    checks++;
    if (wr_cnt !== 2 || ill_cnt !== 0) begin
      failures++;
      $display("FAIL b2b_counts got writes=%0d illegal=%0d exp writes=2 illegal=0", wr_cnt, ill_cnt);
    end
    checks++;
    if (rf[7] !== 16'h0003 || rf[8] !== 16'h0000) begin
      failures++;
      $display("FAIL b2b_results got r7=%h r8=%h exp r7=0003 r8=0000", rf[7], rf[8]);
    end
    $display("txn B2B OR r7=%h AND r8=%h", rf[7], rf[8]);
  endtask

  task automatic test_reset_mid_op();
    int wr_cnt = 0;
    preload(4'd1, 16'd5);
    preload(4'd2, 16'd3);
    preload(4'd9, 16'h5555);
    issue(16'h1129);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (alu_sel !== 3'd1) begin
      failures++;
      $display("FAIL rstmid_exec got sel=%h exp=1", alu_sel);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({instr_ready, wr_en, done, alu_sel} !== 6'b100000 || alu_a !== 16'd0 || alu_b !== 16'd0) begin
      failures++;
      $display("FAIL rstmid_now got ctl=%b a=%h b=%h exp ctl=100000 a=0 b=0",
               {instr_ready, wr_en, done, alu_sel}, alu_a, alu_b);
    end
`ifdef ALU_ISSUE_FLAGS_EN
    checks++;
    if ({zero_flag, neg_flag} !== 2'b00) begin
      failures++;
      $display("FAIL rstmid_flags got zn=%b exp=00", {zero_flag, neg_flag});
    end
`endif
    repeat (3) begin
      @(negedge clk);
      if (wr_en) wr_cnt++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (wr_en) wr_cnt++;
    checks++;
    if (wr_cnt !== 0 || rf[9] !== 16'h5555 || instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_nowrite got writes=%0d r9=%h ready=%b exp writes=0 r9=5555 ready=1",
               wr_cnt, rf[9], instr_ready);
    end
    issue(16'h112A);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd10 || wr_data !== 16'h0008) begin
      failures++;
      $display("FAIL rstmid_add got we=%b wa=%h wd=%h exp we=1 wa=a wd=0008", wr_en, wr_addr, wr_data);
    end
    $display("txn ADD after reset instr=112A rd=%0d data=%h", wr_addr, wr_data);
    @(negedge clk);
    checks++;
    if (rf[10] !== 16'h0008) begin
      failures++;
      $display("FAIL rstmid_rf got=%h exp=0008", rf[10]);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_clr_inc();
    test_illegal();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
